// File: rtl/ser_tx_pkg.sv
// Shared definitions for the ser_tx framed serial transmitter.
//   state_t    : transmitter FSM states (2-bit encoding)
//   LINE_IDLE  : level of the serial line between frames and during the stop bit
//   LINE_START : level of the start bit
//   cnt_width  : counter width helper, max(1, $clog2(n))
package ser_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // A counter over n values never needs fewer than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_tx_bit_tick_gen.sv
// Bit-period counter for ser_tx.
// Counts 0..CLKS_PER_BIT-1 while enabled and wraps; o_tick marks the last clock
// of each bit period.
//   i_clk   : clock, rising edge
//   i_rstn  : asynchronous active-low reset
//   i_en    : count enable (frame in progress)
//   i_clr   : restart the period at 0 (word accepted)
//   o_tick  : high during the last clock of a bit period
module bit_tick_gen
  import ser_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (cnt == LAST);

endmodule

// File: rtl/ser_tx.sv
// Parallel-in / serial-out framed transmitter.
// Accepts a word over valid/ready and sends start bit (0), BW_DATA data bits,
// stop bit (1), each held for CLKS_PER_BIT clocks. Line idles at 1.
//   i_clk   : clock, rising edge
//   i_rstn  : asynchronous active-low reset (abandons any frame in progress)
//   i_data  : word to send, sampled only on accept
//   i_valid : source has a word on i_data
//   o_ready : a word can be accepted this cycle (idle, or last stop-bit clock)
//   o_txd   : registered serial line
//   o_busy  : frame in progress
//   o_done  : one-cycle pulse after the stop bit completes
module ser_tx
  import ser_tx_pkg::*;
#(
  parameter int unsigned BW_DATA      = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_txd,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned BI = cnt_width(BW_DATA);
  localparam logic [BI-1:0] LAST_BIT = BI'(BW_DATA - 1);

  state_t             state;
  logic [BW_DATA-1:0] shreg;
  logic [BW_DATA-1:0] sh_next;
  logic [BI-1:0]      bidx;
  logic               tick;
  logic               accept;

  // Accepting during the last stop clock chains frames with no idle gap
  // while still giving the stop bit its full period.
  assign o_ready = (state == ST_IDLE) || ((state == ST_STOP) && tick);
  assign accept  = i_valid && o_ready;
  assign o_busy  = (state != ST_IDLE);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_en   (o_busy),
    .i_clr  (accept),
    .o_tick (tick)
  );

  function automatic logic out_bit(input logic [BW_DATA-1:0] v);
    return LSB_FIRST ? v[0] : v[BW_DATA-1];
  endfunction

  always_comb begin
    sh_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
  end

  // o_txd is registered, so each branch loads the level of the bit that
  // starts on the next clock (for data, the bit after the shift).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_IDLE;
      o_txd  <= LINE_IDLE;
      o_done <= 1'b0;
      shreg  <= '0;
      bidx   <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_START;
            o_txd <= LINE_START;
            shreg <= i_data;
            bidx  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            o_txd <= out_bit(shreg);
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bidx == LAST_BIT) begin
              state <= ST_STOP;
              o_txd <= LINE_IDLE;
            end else begin
              shreg <= sh_next;
              bidx  <= bidx + 1'b1;
              o_txd <= out_bit(sh_next);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            o_done <= 1'b1;
            if (accept) begin
              state <= ST_START;
              o_txd <= LINE_START;
              shreg <= i_data;
              bidx  <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx.sv
// Self-checking bench for ser_tx.
// Main instance (8 bits, 4 clk/bit, LSB first) is driven with directed and
// random words; accepted words go into a scoreboard queue and a monitor
// decodes the line cycle by cycle against the expected frame.
// Two small instances cover MSB-first order and the 1-bit/1-clock minimum.
module tb_ser_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  // main instance
  logic       rstn = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = '0;
  logic       ready, txd, busy, done;

  ser_tx #(.BW_DATA(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_txd(txd), .o_busy(busy), .o_done(done));

  // MSB-first instance
  logic       rstn_b = 1'b0;
  logic       valid_b = 1'b0;
  logic [7:0] data_b = '0;
  logic       ready_b, txd_b, busy_b, done_b;

  ser_tx #(.BW_DATA(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) dut_msb (
    .i_clk(clk), .i_rstn(rstn_b), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_txd(txd_b), .o_busy(busy_b), .o_done(done_b));

  // minimum-parameter instance
  logic       valid_c = 1'b0;
  logic [0:0] data_c = '0;
  logic       ready_c, txd_c, busy_c, done_c;

  ser_tx #(.BW_DATA(1), .CLKS_PER_BIT(1), .LSB_FIRST(1'b1)) dut_min (
    .i_clk(clk), .i_rstn(rstn_b), .i_data(data_c), .i_valid(valid_c),
    .o_ready(ready_c), .o_txd(txd_c), .o_busy(busy_c), .o_done(done_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Level of bit period b of an 8-bit frame carrying w.
  function automatic logic frame_bit(input logic [7:0] w, input int b, input bit lsb);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return lsb ? w[b-1] : w[8-b];
  endfunction

  typedef struct {
    logic [7:0] word;
    int         start;
  } frame_t;

  frame_t sbq[$];
  int busy_until = 0;   // main: ready from this edge count onward
  bit bc_done = 1'b0;

  // ---------------- monitor for the main instance ----------------
  initial begin
    bit     in_frame;
    frame_t cur;
    int     c;
    int     done_at;
    in_frame = 1'b0;
    c = 0;
    done_at = -1;
    cur.word = '0;
    cur.start = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        in_frame = 1'b0;
        done_at = -1;
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        continue;
      end
      check("done", done, (edge_cnt == done_at));
      if (!in_frame && txd == 1'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: actual=txd 0 expected=idle 1 (edge %0d)", edge_cnt);
          cur.word = '0;
          cur.start = edge_cnt;
        end else begin
          cur = sbq.pop_front();
          check("start_latency", edge_cnt, cur.start);
        end
        in_frame = 1'b1;
        c = 0;
      end
      if (in_frame) begin
        check("busy", busy, 1);
        check("txd", txd, frame_bit(cur.word, c / 4, 1'b1));
        c++;
        if (c == 40) begin
          in_frame = 1'b0;
          done_at = edge_cnt + 1;
        end
      end else begin
        check("idle_txd", txd, 1);
        check("idle_busy", busy, 0);
      end
    end
  end

  // One cycle of main stimulus, entered and left at a falling edge.
  task automatic drive(input logic v, input logic [7:0] d, output bit acc);
    bit mr;
    valid = v;
    data  = d;
    mr = (edge_cnt >= busy_until);
    check("ready", ready, mr);
    acc = v && mr;
    if (acc) begin
      sbq.push_back('{word: d, start: edge_cnt + 1});
      busy_until = edge_cnt + 1 + 39;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), a);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    bit a;
    int ready_cnt, done_cnt, idx;
    logic [7:0] words [2];
    words[0] = 8'h00;
    words[1] = 8'hFF;

    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_txd", txd, 1);
    rstn = 1'b1;
    busy_until = edge_cnt;

    // single word A5
    drive(1'b1, 8'hA5, a);
    check("accept_a5", a, 1);
    idle_cycles(45);

    // valid held high, 00 then FF back to back
    ready_cnt = 0;
    done_cnt = 0;
    idx = 0;
    for (int i = 0; i < 82; i++) begin
      if (i < 80 && ready) ready_cnt++;
      if (done) done_cnt++;
      if (idx < 2) begin
        drive(1'b1, words[idx], a);
        if (a) idx++;
      end else begin
        drive(1'b0, 8'h55, a);
      end
    end
    check("b2b_ready_cycles", ready_cnt, 2);
    check("b2b_done_pulses", done_cnt, 2);
    idle_cycles(5);

    // mid-frame valid pulses with other data are ignored
    drive(1'b1, 8'h5A, a);
    idle_cycles(9);
    drive(1'b1, 8'hFF, a);
    check("midframe_no_accept", a, 0);
    idle_cycles(14);
    drive(1'b1, 8'h00, a);
    check("midframe_no_accept2", a, 0);
    idle_cycles(20);

    // reset during DATA of 3C
    drive(1'b1, 8'h3C, a);
    idle_cycles(15);
    valid = 1'b0;
    rstn = 1'b0;
    sbq.delete();
    #2;
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    busy_until = edge_cnt;
    drive(1'b1, 8'hC3, a);
    check("accept_c3", a, 1);
    idle_cycles(45);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) != 0), 8'($urandom), a);
    end

    // drain, bounded
    begin
      int n;
      n = 0;
      while ((sbq.size() != 0 || edge_cnt < busy_until + 3) && n < 120) begin
        drive(1'b0, 8'h00, a);
        n++;
      end
      check("drain_queue_empty", sbq.size(), 0);
    end

    begin
      int n;
      n = 0;
      while (!bc_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("side_tests_finished", bc_done, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- MSB-first and minimum-parameter instances ----------------
  initial begin
    logic [7:0] w;
    logic [2:0] exp_min;
    repeat (3) @(negedge clk);
    rstn_b = 1'b1;
    @(negedge clk);

    // MSB first, A5
    w = 8'hA5;
    check("msb_ready", ready_b, 1);
    valid_b = 1'b1;
    data_b = w;
    @(negedge clk);
    valid_b = 1'b0;
    data_b = 8'h00;
    for (int k = 0; k < 40; k++) begin
      check("msb_txd", txd_b, frame_bit(w, k / 4, 1'b0));
      check("msb_done_low", done_b, 0);
      @(negedge clk);
    end
    check("msb_done", done_b, 1);
    check("msb_idle_busy", busy_b, 0);
    @(negedge clk);
    check("msb_done_once", done_b, 0);

    // 1 bit, 1 clock per bit: frames for 1 then 0
    for (int j = 0; j < 2; j++) begin
      data_c = (j == 0) ? 1'b1 : 1'b0;
      exp_min = {1'b1, data_c, 1'b0};   // stop, data, start (LSB sent first)
      check("min_ready", ready_c, 1);
      valid_c = 1'b1;
      @(negedge clk);
      valid_c = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check("min_txd", txd_c, exp_min[k]);
        check("min_busy", busy_c, 1);
        @(negedge clk);
      end
      check("min_done", done_c, 1);
      check("min_idle_txd", txd_c, 1);
      check("min_idle_busy", busy_c, 0);
      @(negedge clk);
      check("min_done_once", done_c, 0);
    end
    bc_done = 1'b1;
  end

  // global time bound
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: actual=timeout expected=finish (edge %0d)", edge_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
